// File: rtl/dcnn_s0_oif_pkg.sv
// dcnn_s0_oif_pkg: shared widths, beat layout and sizing helpers for the DCNN output IO interface
package dcnn_s0_oif_pkg;

    localparam int DW_DEF    = 32;
    localparam int IODW_DEF  = 64;
    localparam int DEPTH_DEF = 4;

    function automatic int ratio(input int dw, input int iodw);
        return iodw / dw;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int RATIO_DEF = IODW_DEF / DW_DEF;

    typedef struct packed {
        logic [IODW_DEF-1:0]  data;
        logic [RATIO_DEF-1:0] keep;
        logic                 last;
    } beat_t;

endpackage

// File: rtl/dcnn_s0_oif_if.sv
// dcnn_s0_oif_if: two-lane core-word input and packed IO-beat output bundle
interface dcnn_s0_oif_if
    import dcnn_s0_oif_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int IODW = IODW_DEF
);
    localparam int RATIO = ratio(DW, IODW);

    logic [1:0]            core_vld;
    logic [1:0]            core_rdy;
    logic [1:0][DW-1:0]    core_data;
    logic [1:0]            core_last;
    logic [1:0]            io_data_vld;
    logic [1:0]            io_data_rdy;
    logic [1:0][IODW-1:0]  io_data_out;
    logic [1:0][RATIO-1:0] io_data_keep;
    logic [1:0]            io_data_last;

    modport slave (
        input  core_vld, core_data, core_last, io_data_rdy,
        output core_rdy, io_data_vld, io_data_out, io_data_keep, io_data_last
    );

    modport master (
        output core_vld, core_data, core_last, io_data_rdy,
        input  core_rdy, io_data_vld, io_data_out, io_data_keep, io_data_last
    );

endinterface

// File: rtl/dcnn_s0_oif_lane.sv
// dcnn_s0_oif_lane: packs RATIO core words into one IO beat and buffers beats in a small flop FIFO
module dcnn_s0_oif_lane
    import dcnn_s0_oif_pkg::*;
#(
    parameter int   DW    = DW_DEF,
    parameter int   IODW  = IODW_DEF,
    parameter int   DEPTH = DEPTH_DEF,
    localparam int  RATIO = ratio(DW, IODW),
    localparam int  PW    = ptr_w(DEPTH),
    localparam int  CW    = $clog2(RATIO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_vld,
    output logic             core_rdy,
    input  logic [DW-1:0]    core_data,
    input  logic             core_last,
    output logic             io_vld,
    input  logic             io_rdy,
    output logic [IODW-1:0]  io_data,
    output logic [RATIO-1:0] io_keep,
    output logic             io_last
);
    typedef struct packed {
        logic [IODW-1:0]  data;
        logic [RATIO-1:0] keep;
        logic             last;
    } slot_t;

    logic [CW-1:0]    cnt;
    logic [IODW-1:0]  pack_data;
    logic [RATIO-1:0] pack_keep;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    slot_t            mem [DEPTH];
    slot_t            beat;
    slot_t            head;
    logic             full;
    logic             empty;
    logic             acc;
    logic             done;
    logic             pop;

    assign full     = (wptr[PW-2:0] == rptr[PW-2:0]) && (wptr[PW-1] != rptr[PW-1]);
    assign empty    = wptr == rptr;
    assign core_rdy = !rst && !full;
    assign acc      = core_vld && core_rdy;
    assign done     = acc && (cnt == CW'(RATIO - 1) || core_last);
    assign io_vld   = !rst && !empty;
    assign pop      = io_vld && io_rdy;
    assign io_data  = head.data;
    assign io_keep  = head.keep;
    assign io_last  = head.last;

    // merge the incoming word into its slot and mask the FIFO head when nothing is buffered
    always_comb begin
        beat.data = pack_data | (IODW'(core_data) << (DW * cnt));
        beat.keep = pack_keep | (RATIO'(1) << cnt);
        beat.last = core_last;
        head      = io_vld ? mem[rptr[PW-2:0]] : '0;
    end

    // slot counter, partial beat and FIFO pointers; reset drops any partial or queued beats
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pack_data <= '0;
            pack_keep <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            if (acc) begin
                cnt       <= done ? '0 : cnt + 1'b1;
                pack_data <= done ? '0 : beat.data;
                pack_keep <= done ? '0 : beat.keep;
            end
            if (done) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // beat storage needs no reset since reads are masked while empty
    always_ff @(posedge clk) begin
        if (done) mem[wptr[PW-2:0]] <= beat;
    end

endmodule

// File: rtl/dcnn_s0_oif.sv
// dcnn_s0_oif: two independent output lanes packing core words into IO beats
module dcnn_s0_oif
    import dcnn_s0_oif_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IODW  = IODW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic           clk,
    input logic           rst,
    dcnn_s0_oif_if.slave  bus
);
    if (IODW % DW != 0 || IODW / DW < 2 || IODW / DW > 4) begin : g_bad_ratio
        $error("IODW/DW must be an integer in 2..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane
        dcnn_s0_oif_lane #(
            .DW    (DW),
            .IODW  (IODW),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .core_vld  (bus.core_vld[l]),
            .core_rdy  (bus.core_rdy[l]),
            .core_data (bus.core_data[l]),
            .core_last (bus.core_last[l]),
            .io_vld    (bus.io_data_vld[l]),
            .io_rdy    (bus.io_data_rdy[l]),
            .io_data   (bus.io_data_out[l]),
            .io_keep   (bus.io_data_keep[l]),
            .io_last   (bus.io_data_last[l])
        );
    end

endmodule
